// File: rtl/tankb_input_cond.sv
// Input conditioner for the Tank Battalion core: synchronises and debounces the
// player/reset buttons, emits edge pulses and sequences the core reset.

module tankb_input_cond_db #(
    parameter int DB_SAMPLES = 4,
    parameter int DB_W       = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic raw_n_i,
    output logic level_o,
    output logic level_d_o
);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_SAMPLES - 1);

    logic [1:0]      sync_q;
    logic            s;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Raw input is active-low; the sample is active-high (1 = pressed).
    assign s = ~sync_q[1];

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_n_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;
endmodule

module tankb_input_cond #(
    parameter int NBTN       = 5,
    parameter int TICK_DIV   = 18000,
    parameter int DB_SAMPLES = 4,
    parameter int RST_HOLD   = 16
) (
    input  logic            CLK18,
    input  logic            nRESET,
    input  logic [NBTN-1:0] BUTTONS,
    input  logic            BTN_RESET,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_rise,
    output logic [NBTN-1:0] btn_fall,
    output logic            game_nreset
);
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int DB_W   = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PRESS = 2'd2;

    logic [CNT_W-1:0] pre_q;
    logic             tick;

    assign tick = (pre_q == TICK_LAST);

    always_ff @(posedge CLK18 or negedge nRESET) begin
        if (!nRESET)   pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + CNT_W'(1);
    end

    // Lane NBTN is the reset button; its level never reaches btn_level.
    logic [NBTN:0] raw_n, lvl_q, lvl_d;

    assign raw_n = {BTN_RESET, BUTTONS};

    for (genvar i = 0; i <= NBTN; i++) begin : g_lane
        tankb_input_cond_db #(
            .DB_SAMPLES (DB_SAMPLES),
            .DB_W       (DB_W)
        ) u_lane (
            .clk       (CLK18),
            .rst_n     (nRESET),
            .tick_i    (tick),
            .raw_n_i   (raw_n[i]),
            .level_o   (lvl_q[i]),
            .level_d_o (lvl_d[i])
        );
    end

    logic [NBTN-1:0] rise_q, fall_q;

    always_ff @(posedge CLK18 or negedge nRESET) begin
        if (!nRESET) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= lvl_d[NBTN-1:0] & ~lvl_q[NBTN-1:0];
            fall_q <= ~lvl_d[NBTN-1:0] & lvl_q[NBTN-1:0];
        end
    end

    assign btn_level = lvl_q[NBTN-1:0];
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

    // The FSM reacts to the reset level being decided on this same edge.
    logic              rst_lvl;
    logic [1:0]        st_q, st_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              nres_q;

    assign rst_lvl = lvl_d[NBTN];

    always_comb begin
        st_d   = st_q;
        hold_d = hold_q;
        if (tick) begin
            case (st_q)
                ST_HOLD: begin
                    if (rst_lvl) begin
                        hold_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        st_d   = ST_RUN;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (rst_lvl) st_d = ST_PRESS;
                end
                ST_PRESS: begin
                    if (!rst_lvl) begin
                        st_d   = ST_HOLD;
                        hold_d = '0;
                    end
                end
                default: begin
                    st_d   = ST_HOLD;
                    hold_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK18 or negedge nRESET) begin
        if (!nRESET) begin
            st_q   <= ST_HOLD;
            hold_q <= '0;
            nres_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            hold_q <= hold_d;
            nres_q <= (st_d == ST_RUN);
        end
    end

    assign game_nreset = nres_q;
endmodule
